_alu29x03_seq: RTL and testbench

Nibble-serial 16-bit operation sequencer that drives a single 4-bit `_alu29x03` slice from its controlling side. It accepts one operation request via a start/busy handshake and decodes the opcode into the slice's `ctrl`/`cn` fields. It presents operand nibbles LSB-first over four cycles, chains the carry from `cn4` back into `cn`, and assembles the 16-bit result and flags. It sits between microcode/test-sequencing logic and the ALU slice model.

---
 rtl/_alu29x03_pkg.sv | 50 +++++
 rtl/_alu29x03_dec.sv | 45 ++++
 rtl/_alu29x03_seq.sv | 149 ++++++++++++++
 tb/tb__alu29x03_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/_alu29x03_pkg.sv
// -----------------------------------------------------------------------------
// _alu29x03_pkg
// Shared definitions for sequencers driving a 4-bit _alu29x03 slice:
//   - opcode values OP_ZERO..OP_INCA
//   - ctrl_t: the seven live slice control bits, MSB first
//     {m,k,j,ben,aen,bpol,apol}, so ctrl_t packs into ctrl[6:0]
//   - state_e: sequencer FSM states
// -----------------------------------------------------------------------------
package _alu29x03_pkg;

  localparam int NIB_W = 4;

  // Constant / logic operations
  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_ONES  = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_XNOR  = 4'd3;
  localparam logic [3:0] OP_NAND  = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  // Pass operations
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_NOTA  = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_NOTB  = 4'd11;
  // Arithmetic operations
  localparam logic [3:0] OP_ADD   = 4'd12;
  localparam logic [3:0] OP_SUB   = 4'd13;
  localparam logic [3:0] OP_RSUB  = 4'd14;
  localparam logic [3:0] OP_INCA  = 4'd15;

  // Bit 0 is apol, bit 6 is m.
  typedef struct packed {
    logic m;
    logic k;
    logic j;
    logic ben;
    logic aen;
    logic bpol;
    logic apol;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/_alu29x03_dec.sv
// -----------------------------------------------------------------------------
// _alu29x03_dec
// Combinational opcode decoder for the _alu29x03 slice. Reusable by any
// sequencer that drives the slice.
//   op_i       [3:0] opcode
//   ctrl_o     ctrl_t slice control bits {m,k,j,ben,aen,bpol,apol}
//   is_arith_o high for the carry-using operations (ADD/SUB/RSUB/INCA)
// -----------------------------------------------------------------------------
module _alu29x03_dec
  import _alu29x03_pkg::*;
(
  input  logic [3:0] op_i,
  output ctrl_t      ctrl_o,
  output logic       is_arith_o
);

  // NOTE: a default assignment ahead of the case keeps every path assigned,
  // so no latch can be inferred even if the case is later edited.
  always_comb begin
    ctrl_o = '0;
    unique case (op_i)
      OP_ZERO:  ctrl_o = 7'b000_0000;
      OP_ONES:  ctrl_o = 7'b100_0000;
      OP_XOR:   ctrl_o = 7'b000_1100;
      OP_XNOR:  ctrl_o = 7'b000_1101;
      OP_NAND:  ctrl_o = 7'b001_1100;
      OP_NOR:   ctrl_o = 7'b101_1111;
      OP_AND:   ctrl_o = 7'b101_1100;
      OP_OR:    ctrl_o = 7'b001_1111;
      OP_PASSA: ctrl_o = 7'b000_0100;
      OP_NOTA:  ctrl_o = 7'b000_0101;
      OP_PASSB: ctrl_o = 7'b000_1000;
      OP_NOTB:  ctrl_o = 7'b000_1010;
      OP_ADD:   ctrl_o = 7'b010_1100;
      OP_SUB:   ctrl_o = 7'b010_1110;
      OP_RSUB:  ctrl_o = 7'b010_1101;
      OP_INCA:  ctrl_o = 7'b010_0100;
      default:  ctrl_o = '0;
    endcase
  end

  // The k bit selects the slice adder, which is exactly the arithmetic group.
  assign is_arith_o = ctrl_o.k;

endmodule

// File: rtl/_alu29x03_seq.sv
// -----------------------------------------------------------------------------
// _alu29x03_seq
// Nibble-serial 16-bit operation sequencer for one 4-bit _alu29x03 slice.
// Accepts a request in IDLE, walks the four operand nibbles LSB-first through
// the slice (chaining cn4 -> cn for arithmetic), then pulses done for one cycle.
//   clk, rst         clock, synchronous active-high reset
//   start            request strobe, honoured only in IDLE
//   op, opa, opb     opcode and 16-bit operands
//   cin              carry into nibble 0 (arithmetic ops)
//   busy, done       handshake: busy from accept until DONE exits; done pulse
//   result           assembled 16-bit F
//   cout, ovr_o      nibble-3 cn4/ovr for arithmetic ops, else 0
//   neg, zero        result[15] and result==0
//   a, b, ctrl, cn   slice drive (all zero outside RUN)
//   f, cn4, ovr      slice response, combinational from a/b/ctrl/cn
// -----------------------------------------------------------------------------
module _alu29x03_seq
  import _alu29x03_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovr_o,
  output logic        neg,
  output logic        zero,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [12:0] ctrl,
  output logic        cn,
  input  logic [3:0]  f,
  input  logic        cn4,
  input  logic        ovr
);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [3:0]  op_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic        cin_q;
  logic        carry_q;
  logic [15:0] result_q;
  logic        cout_q;
  logic        ovr_q;
  logic        busy_q;
  logic        done_q;

  ctrl_t       dec_ctrl;
  logic        dec_arith;
  logic [3:0]  nib_lsb;

  // Decode the latched opcode so ctrl stays stable even if op changes mid-run.
  _alu29x03_dec u_dec (
    .op_i       (op_q),
    .ctrl_o     (dec_ctrl),
    .is_arith_o (dec_arith)
  );

  // Bit offset of the current nibble: idx * 4.
  assign nib_lsb = {idx_q, 2'b00};

  // Slice drive: only RUN presents operands; IDLE and DONE park the port at 0.
  always_comb begin
    a    = '0;
    b    = '0;
    ctrl = '0;
    cn   = 1'b0;
    if (state_q == ST_RUN) begin
      a    = opa_q[nib_lsb +: NIB_W];
      b    = opb_q[nib_lsb +: NIB_W];
      ctrl = {6'b0, dec_ctrl};
      // Logic ops ignore carry; arithmetic uses cin on nibble 0, then the chain.
      cn   = dec_arith & ((idx_q == 2'd0) ? cin_q : carry_q);
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its peers.
  // Reset is synchronous; all outputs and any partial result return to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            opa_q   <= opa;
            opb_q   <= opb;
            cin_q   <= cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Slice is combinational: f/cn4/ovr belong to the nibble on the port now.
          result_q[nib_lsb +: NIB_W] <= f;
          carry_q <= cn4;
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Carry out of nibble 3 is reported, never fed back.
            cout_q  <= dec_arith & cn4;
            ovr_q   <= dec_arith & ovr;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start is not looked at here, so a request in this cycle is dropped.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovr_o  = ovr_q;
  assign neg    = result_q[15];
  assign zero   = (result_q == 16'h0000);

endmodule

// File: tb/tb__alu29x03_seq.sv
// -----------------------------------------------------------------------------
// tb__alu29x03_seq
// Self-checking bench for _alu29x03_seq. A behavioural 4-bit slice sits on the
// ALU port; expected results come from whole-word 16-bit arithmetic.
// -----------------------------------------------------------------------------
module tb__alu29x03_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovr_o;
  logic        neg;
  logic        zero;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [12:0] ctrl;
  logic        cn;
  logic [3:0]  f;
  logic        cn4;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  _alu29x03_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovr_o  (ovr_o),
    .neg    (neg),
    .zero   (zero),
    .a      (a),
    .b      (b),
    .ctrl   (ctrl),
    .cn     (cn),
    .f      (f),
    .cn4    (cn4),
    .ovr    (ovr)
  );

  // Behavioural 4-bit slice: ctrl[6:0] = {m,k,j,ben,aen,bpol,apol}.
  logic [3:0] sa;
  logic [3:0] sb;
  logic [4:0] ssum;
  always_comb begin
    sa   = (ctrl[2] ? a : 4'h0) ^ {4{ctrl[0]}};
    sb   = (ctrl[3] ? b : 4'h0) ^ {4{ctrl[1]}};
    ssum = {1'b0, sa} + {1'b0, sb} + {4'b0, cn};
    f    = 4'h0;
    cn4  = 1'b0;
    ovr  = 1'b0;
    if (ctrl[5]) begin
      f   = ssum[3:0];
      cn4 = ssum[4];
      ovr = (sa[3] == sb[3]) && (ssum[3] != sa[3]);
    end else if (ctrl[4]) begin
      f = ctrl[6] ? (sa & sb) : ~(sa & sb);
    end else begin
      f = ctrl[6] ? ~(sa ^ sb) : (sa ^ sb);
    end
  end

  // Opcode -> ctrl[6:0] table.
  logic [6:0] ctrl_tab [16] = '{
    7'b0000000, 7'b1000000, 7'b0001100, 7'b0001101,
    7'b0011100, 7'b1011111, 7'b1011100, 7'b0011111,
    7'b0000100, 7'b0000101, 7'b0001000, 7'b0001010,
    7'b0101100, 7'b0101110, 7'b0101101, 7'b0100100
  };

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovr;
  } exp_t;

  function automatic logic is_arith(input logic [3:0] o);
    return o >= 4'd12;
  endfunction

  // Adder inputs {x, y} for the arithmetic ops.
  function automatic logic [31:0] arith_xy(input logic [3:0] o,
                                           input logic [15:0] x, input logic [15:0] y);
    case (o)
      4'd12:   return {x, y};
      4'd13:   return {x, ~y};
      4'd14:   return {~x, y};
      default: return {x, 16'h0000};
    endcase
  endfunction

  function automatic exp_t ref_model(input logic [3:0] o, input logic [15:0] x,
                                     input logic [15:0] y, input logic c);
    exp_t        e;
    logic [31:0] xy;
    logic [16:0] s;
    e.cout = 1'b0;
    e.ovr  = 1'b0;
    case (o)
      4'd0:  e.res = 16'h0000;
      4'd1:  e.res = 16'hFFFF;
      4'd2:  e.res = x ^ y;
      4'd3:  e.res = ~(x ^ y);
      4'd4:  e.res = ~(x & y);
      4'd5:  e.res = ~(x | y);
      4'd6:  e.res = x & y;
      4'd7:  e.res = x | y;
      4'd8:  e.res = x;
      4'd9:  e.res = ~x;
      4'd10: e.res = y;
      4'd11: e.res = ~y;
      default: begin
        xy     = arith_xy(o, x, y);
        s      = {1'b0, xy[31:16]} + {1'b0, xy[15:0]} + {16'b0, c};
        e.res  = s[15:0];
        e.cout = s[16];
        e.ovr  = (xy[31] == xy[15]) && (s[15] != xy[31]);
      end
    endcase
    return e;
  endfunction

  // Carry entering nibble k of the whole-word addition (k=0 gives c).
  function automatic logic carry_into(input logic [3:0] o, input logic [15:0] x,
                                      input logic [15:0] y, input logic c, input int k);
    logic [31:0] xy;
    logic [15:0] mask;
    logic [16:0] s;
    xy   = arith_xy(o, x, y);
    mask = 16'((32'h1 << (4 * k)) - 1);
    s    = {1'b0, xy[31:16] & mask} + {1'b0, xy[15:0] & mask} + {16'b0, c};
    return s[4 * k];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with per-cycle checks of handshake and ALU port.
  // poke_run: pulse start with other operands during RUN (must be ignored).
  // poke_done: hold start high in the DONE cycle (must not be accepted).
  task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input bit poke_run, input bit poke_done);
    exp_t e;
    e     = ref_model(o, x, y, c);
    op    = o;
    opa   = x;
    opb   = y;
    cin   = c;
    start = 1'b1;
    step();              // accept edge T0 passed; now in T0+1
    start = 1'b0;
    op    = 4'($urandom);
    opa   = 16'($urandom);
    opb   = 16'($urandom);
    cin   = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("busy_run%0d", k), 32'(busy), 32'd1);
      check($sformatf("done_run%0d", k), 32'(done), 32'd0);
      check($sformatf("a_nib%0d", k), 32'(a), 32'(x[4*k +: 4]));
      check($sformatf("b_nib%0d", k), 32'(b), 32'(y[4*k +: 4]));
      check($sformatf("ctrl_nib%0d", k), 32'(ctrl), {25'b0, ctrl_tab[o]});
      check($sformatf("cn_nib%0d", k), 32'(cn),
            32'(is_arith(o) ? carry_into(o, x, y, c, k) : 1'b0));
      start = poke_run && (k == 1);
      step();
      start = 1'b0;
    end
    // cycle T0+5
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("result", 32'(result), 32'(e.res));
    check("cout", 32'(cout), 32'(e.cout));
    check("ovr_o", 32'(ovr_o), 32'(e.ovr));
    check("neg", 32'(neg), 32'(e.res[15]));
    check("zero", 32'(zero), 32'(e.res == 16'h0000));
    check("ctrl_done", 32'(ctrl), 32'd0);
    check("port_done", {27'b0, a, cn}, 32'd0);
    start = poke_done;
    step();              // T0+6: IDLE
    start = 1'b0;
    check("busy_idle", 32'(busy), 32'd0);
    check("done_idle", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'(e.res));
    if (poke_done) begin
      step();            // a late accept would show busy here
      check("busy_after_late_start", 32'(busy), 32'd0);
      check("result_hold2", 32'(result), 32'(e.res));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    opa   = '0;
    opb   = '0;
    cin   = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {28'b0, cout, ovr_o, neg, zero}, 32'b0001);
    check("rst_port", {11'b0, a, b, ctrl, cn}, 32'd0);
    rst = 1'b0;
    step();

    // Directed cases
    run_op(4'd12, 16'h1234, 16'h0FFF, 1'b0, 0, 0);
    run_op(4'd12, 16'hFFFF, 16'h0001, 1'b0, 0, 0);
    run_op(4'd13, 16'h0005, 16'h0004, 1'b1, 0, 0);
    run_op(4'd14, 16'h0004, 16'h0005, 1'b1, 0, 0);
    run_op(4'd6,  16'hC0A5, 16'hA0F0, 1'b0, 0, 0);
    run_op(4'd1,  16'h1234, 16'h5678, 1'b1, 0, 0);
    run_op(4'd12, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
    // start during RUN and in the DONE cycle must both be ignored
    run_op(4'd12, 16'h1111, 16'h2222, 1'b0, 1, 1);

    // Reset during nibble 2 of an ADD
    op    = 4'd12;
    opa   = 16'hABCD;
    opb   = 16'h1357;
    cin   = 1'b1;
    start = 1'b1;
    step();              // T0+1
    start = 1'b0;
    step();              // T0+2
    step();              // T0+3: nibble 2 on the port
    check("mid_a_nib2", 32'(a), 32'hB);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_ctrl", 32'(ctrl), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    run_op(4'd12, 16'hABCD, 16'h1357, 1'b1, 0, 0);

    // Randomised operations against the word-level model
    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above is ever stalled.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
